// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath slice.
//   DATA_W   : bus/register width
//   RES_W    : ALU result / Z register width (two words)
//   alu_op_e : ALU operation selected from the op strobes
package datapath_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RES_W  = 2 * DATA_W;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_INC  = 2'd1,
    OP_AND  = 2'd2,
    OP_ROL  = 2'd3
  } alu_op_e;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU for the datapath.
//   A  : first operand (Y register)
//   B  : second operand (current bus value)
//   op : operation to perform
//   C  : double-width result; the upper word is always zero
// Optional rotate-left is present only when DATAPATH_ROL_EN is defined.
module datapath_alu #(
  parameter int unsigned DATA_W = datapath_pkg::DATA_W
) (
  input  logic [DATA_W-1:0]    A,
  input  logic [DATA_W-1:0]    B,
  input  datapath_pkg::alu_op_e op,
  output logic [2*DATA_W-1:0]  C
);

  import datapath_pkg::*;

  logic [DATA_W-1:0] res;

`ifdef DATAPATH_ROL_EN
  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]   rot_amt;
  logic [DATA_W-1:0] rot_res;

  // A right shift by the full width yields zero, so amount 0 returns A unchanged.
  assign rot_amt = B[SH_W-1:0];
  assign rot_res = (A << rot_amt) | (A >> (DATA_W'(DATA_W) - DATA_W'(rot_amt)));
`endif

  // Low-word result; carry out of the increment is dropped.
  always_comb begin
    res = '0;
    case (op)
      OP_INC:  res = B + DATA_W'(1);
      OP_AND:  res = A & B;
`ifdef DATAPATH_ROL_EN
      OP_ROL:  res = rot_res;
`endif
      default: res = '0;
    endcase
  end

  assign C = {{DATA_W{1'b0}}, res};

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: PC, IR, MAR, MDR, Y, Z and R1..R3 around one
// shared bus and an ALU.
//   clock, clear      : rising-edge clock, asynchronous active-low reset
//   Mdatain           : memory read data into the MDR input mux
//   PCout..R3out      : bus drive enables (priority PC highest, R3 lowest)
//   PCin..R3in        : register load enables
//   Read              : MDR source select (1 = Mdatain, 0 = bus)
//   IncPc, AND, [ROL] : ALU op strobes; any strobe also loads Z
//   BusMuxOut         : current bus value (combinational)
//   MAR_q, IR_q       : MAR and IR contents
// Build option: define DATAPATH_ROL_EN to add the ROL port and rotate op.
module datapath #(
  parameter int unsigned DATA_W = datapath_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] Mdatain,
  input  logic              PCout,
  input  logic              Zhighout,
  input  logic              Zlowout,
  input  logic              MDRout,
  input  logic              R1out,
  input  logic              R2out,
  input  logic              R3out,
  input  logic              PCin,
  input  logic              IRin,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Yin,
  input  logic              Zin,
  input  logic              R1in,
  input  logic              R2in,
  input  logic              R3in,
  input  logic              Read,
  input  logic              IncPc,
  input  logic              AND,
`ifdef DATAPATH_ROL_EN
  input  logic              ROL,
`endif
  output logic [DATA_W-1:0] BusMuxOut,
  output logic [DATA_W-1:0] MAR_q,
  output logic [DATA_W-1:0] IR_q
);

  import datapath_pkg::*;

  localparam int unsigned Z_W = 2 * DATA_W;

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] y;
  logic [DATA_W-1:0] r1;
  logic [DATA_W-1:0] r2;
  logic [DATA_W-1:0] r3;
  logic [Z_W-1:0]    z;

  logic [DATA_W-1:0] mdr_next;
  logic [Z_W-1:0]    alu_c;
  alu_op_e           op;
  logic              rol_strobe;
  logic              z_load;

`ifdef DATAPATH_ROL_EN
  assign rol_strobe = ROL;
`else
  assign rol_strobe = 1'b0;
`endif

  // Bus source mux, fixed priority; idle bus reads zero.
  always_comb begin
    BusMuxOut = '0;
    if (PCout)         BusMuxOut = pc;
    else if (Zhighout) BusMuxOut = z[Z_W-1:DATA_W];
    else if (Zlowout)  BusMuxOut = z[DATA_W-1:0];
    else if (MDRout)   BusMuxOut = mdr;
    else if (R1out)    BusMuxOut = r1;
    else if (R2out)    BusMuxOut = r2;
    else if (R3out)    BusMuxOut = r3;
  end

  // Op strobe priority: IncPc, then AND, then ROL.
  always_comb begin
    op = OP_NONE;
    if (IncPc)           op = OP_INC;
    else if (AND)        op = OP_AND;
    else if (rol_strobe) op = OP_ROL;
  end

  assign z_load   = Zin | IncPc | AND | rol_strobe;
  assign mdr_next = Read ? Mdatain : BusMuxOut;

  datapath_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .A  (y),
    .B  (BusMuxOut),
    .op (op),
    .C  (alu_c)
  );

  // Register file; a register driving the bus in the same cycle it loads
  // presents its old value and captures the new one at the edge.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pc    <= '0;
      IR_q  <= '0;
      MAR_q <= '0;
      mdr   <= '0;
      y     <= '0;
      z     <= '0;
      r1    <= '0;
      r2    <= '0;
      r3    <= '0;
    end else begin
      if (PCin)   pc    <= BusMuxOut;
      if (IRin)   IR_q  <= BusMuxOut;
      if (MARin)  MAR_q <= BusMuxOut;
      if (MDRin)  mdr   <= mdr_next;
      if (Yin)    y     <= BusMuxOut;
      if (z_load) z     <= alu_c;
      if (R1in)   r1    <= BusMuxOut;
      if (R2in)   r2    <= BusMuxOut;
      if (R3in)   r3    <= BusMuxOut;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: reset checks, a directed vector table,
// abort-on-reset and (when built with DATAPATH_ROL_EN) rotate sequences,
// then randomized control words checked against a behavioural model.
module tb_datapath;

  // Control word bit positions
  localparam logic [19:0] C_PCO  = 20'd1 << 0;
  localparam logic [19:0] C_ZHO  = 20'd1 << 1;
  localparam logic [19:0] C_ZLO  = 20'd1 << 2;
  localparam logic [19:0] C_MDRO = 20'd1 << 3;
  localparam logic [19:0] C_R1O  = 20'd1 << 4;
  localparam logic [19:0] C_R2O  = 20'd1 << 5;
  localparam logic [19:0] C_R3O  = 20'd1 << 6;
  localparam logic [19:0] C_PCI  = 20'd1 << 7;
  localparam logic [19:0] C_IRI  = 20'd1 << 8;
  localparam logic [19:0] C_MARI = 20'd1 << 9;
  localparam logic [19:0] C_MDRI = 20'd1 << 10;
  localparam logic [19:0] C_YI   = 20'd1 << 11;
  localparam logic [19:0] C_ZI   = 20'd1 << 12;
  localparam logic [19:0] C_R1I  = 20'd1 << 13;
  localparam logic [19:0] C_R2I  = 20'd1 << 14;
  localparam logic [19:0] C_R3I  = 20'd1 << 15;
  localparam logic [19:0] C_RD   = 20'd1 << 16;
  localparam logic [19:0] C_INC  = 20'd1 << 17;
  localparam logic [19:0] C_AND  = 20'd1 << 18;
  localparam logic [19:0] C_ROL  = 20'd1 << 19;
  localparam logic [19:0] C_NONE = 20'd0;

  typedef struct {
    logic [19:0] c;
    logic [31:0] md;
    logic [31:0] bus;
    logic [31:0] mar;
    logic [31:0] ir;
  } vec_t;

  logic clock = 1'b0;
  logic clear;
  logic [31:0] Mdatain;
  logic PCout, Zhighout, Zlowout, MDRout, R1out, R2out, R3out;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, R1in, R2in, R3in;
  logic Read, IncPc, and_s;
`ifdef DATAPATH_ROL_EN
  logic rol;
`endif
  logic [31:0] BusMuxOut, MAR_q, IR_q;

  int tests = 0;
  int fails = 0;

  vec_t tbl[$];

  // Reference model state
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_r1, m_r2, m_r3;
  logic [63:0] m_z;

  always #5 clock = ~clock;

  datapath dut (
    .clock     (clock),
    .clear     (clear),
    .Mdatain   (Mdatain),
    .PCout     (PCout),
    .Zhighout  (Zhighout),
    .Zlowout   (Zlowout),
    .MDRout    (MDRout),
    .R1out     (R1out),
    .R2out     (R2out),
    .R3out     (R3out),
    .PCin      (PCin),
    .IRin      (IRin),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .Yin       (Yin),
    .Zin       (Zin),
    .R1in      (R1in),
    .R2in      (R2in),
    .R3in      (R3in),
    .Read      (Read),
    .IncPc     (IncPc),
    .AND       (and_s),
`ifdef DATAPATH_ROL_EN
    .ROL       (rol),
`endif
    .BusMuxOut (BusMuxOut),
    .MAR_q     (MAR_q),
    .IR_q      (IR_q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [19:0] c, input logic [31:0] md);
    PCout    = c[0];
    Zhighout = c[1];
    Zlowout  = c[2];
    MDRout   = c[3];
    R1out    = c[4];
    R2out    = c[5];
    R3out    = c[6];
    PCin     = c[7];
    IRin     = c[8];
    MARin    = c[9];
    MDRin    = c[10];
    Yin      = c[11];
    Zin      = c[12];
    R1in     = c[13];
    R2in     = c[14];
    R3in     = c[15];
    Read     = c[16];
    IncPc    = c[17];
    and_s    = c[18];
`ifdef DATAPATH_ROL_EN
    rol      = c[19];
`endif
    Mdatain  = md;
  endtask

  task automatic add(input logic [19:0] c, input logic [31:0] md,
                     input logic [31:0] bus, input logic [31:0] mar, input logic [31:0] ir);
    vec_t v;
    v.c = c; v.md = md; v.bus = bus; v.mar = mar; v.ir = ir;
    tbl.push_back(v);
  endtask

  // One cycle: drive between edges, check the bus before the next rising edge.
  task automatic step(input string name, input logic [19:0] c, input logic [31:0] md,
                      input logic [31:0] exp_bus);
    @(negedge clock);
    drive(c, md);
    #1;
    check(name, BusMuxOut, exp_bus);
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[30:0], r[31]};
    return r;
  endfunction

  // First enabled source in the listed priority order, else zero.
  function automatic logic [31:0] model_bus(input logic [19:0] c);
    logic [31:0] src [7];
    src[0] = m_pc; src[1] = m_z[63:32]; src[2] = m_z[31:0]; src[3] = m_mdr;
    src[4] = m_r1; src[5] = m_r2; src[6] = m_r3;
    for (int s = 0; s < 7; s++)
      if (c[s]) return src[s];
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0;
    m_r1 = 0; m_r2 = 0; m_r3 = 0; m_z = 64'h0;
  endtask

  task automatic model_step(input logic [19:0] c, input logic [31:0] md, input logic [31:0] bus);
    logic [63:0] res;
    logic        zl;
    logic        rol_on;
`ifdef DATAPATH_ROL_EN
    rol_on = c[19];
`else
    rol_on = 1'b0;
`endif
    res = 64'h0;
    if (c[17])      res = {32'h0, bus + 32'd1};
    else if (c[18]) res = {32'h0, m_y & bus};
    else if (rol_on) res = {32'h0, rotl(m_y, int'(bus[4:0]))};
    zl = c[12] | c[17] | c[18] | rol_on;
    if (c[7])  m_pc  = bus;
    if (c[8])  m_ir  = bus;
    if (c[9])  m_mar = bus;
    if (c[10]) m_mdr = c[16] ? md : bus;
    if (c[11]) m_y   = bus;
    if (zl)    m_z   = res;
    if (c[13]) m_r1  = bus;
    if (c[14]) m_r2  = bus;
    if (c[15]) m_r3  = bus;
  endtask

  initial begin
    // Reset with every enable high
    clear = 1'b1;
    drive('1, 32'hDEADBEEF);
    #2 clear = 1'b0;
    #10;
    check("rst_bus_all_en", BusMuxOut, 32'h0);
    check("rst_mar", MAR_q, 32'h0);
    check("rst_ir", IR_q, 32'h0);

    @(negedge clock);
    drive(C_NONE, 32'h0);
    clear = 1'b1;
    #1;
    check("idle_bus", BusMuxOut, 32'h0);
    for (int i = 0; i < 7; i++) begin
      drive(20'd1 << i, 32'h0);
      #1;
      check($sformatf("rst_src%0d", i), BusMuxOut, 32'h0);
    end

    // Directed vectors: load path, fetch, AND, priority, wrap, read-while-write
    add(C_RD | C_MDRI, 32'h12, 32'h0, 32'h0, 32'h0);
    add(C_MDRO | C_R2I, 32'h0, 32'h12, 32'h0, 32'h0);
    add(C_RD | C_MDRI, 32'h14, 32'h0, 32'h0, 32'h0);
    add(C_MDRO | C_R3I, 32'h0, 32'h14, 32'h0, 32'h0);
    add(C_RD | C_MDRI, 32'h18, 32'h0, 32'h0, 32'h0);
    add(C_MDRO | C_R1I, 32'h0, 32'h18, 32'h0, 32'h0);
    add(C_R1O, 32'h0, 32'h18, 32'h0, 32'h0);
    add(C_R2O, 32'h0, 32'h12, 32'h0, 32'h0);
    add(C_R3O, 32'h0, 32'h14, 32'h0, 32'h0);
    add(C_PCO | C_INC | C_MARI, 32'h0, 32'h0, 32'h0, 32'h0);
    add(C_ZLO | C_PCI | C_RD | C_MDRI, 32'hA, 32'h1, 32'h0, 32'h0);
    add(C_MDRO | C_IRI, 32'h0, 32'hA, 32'h0, 32'h0);
    add(C_PCO, 32'h0, 32'h1, 32'h0, 32'hA);
    add(C_R2O | C_YI, 32'h0, 32'h12, 32'h0, 32'hA);
    add(C_R3O | C_AND, 32'h0, 32'h14, 32'h0, 32'hA);
    add(C_ZLO | C_R1I, 32'h0, 32'h10, 32'h0, 32'hA);
    add(C_R1O, 32'h0, 32'h10, 32'h0, 32'hA);
    add(C_ZHO, 32'h0, 32'h0, 32'h0, 32'hA);
    add(C_PCO | C_R1O, 32'h0, 32'h1, 32'h0, 32'hA);
    add(C_MDRO | C_R3O, 32'h0, 32'hA, 32'h0, 32'hA);
    add(C_RD | C_MDRI, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hA);
    add(C_MDRO | C_PCI | C_MARI, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hA);
    add(C_PCO | C_INC, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hA);
    add(C_ZLO, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hA);
    add(C_ZHO, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hA);
    add(C_ZLO | C_INC, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hA);
    add(C_ZLO, 32'h0, 32'h1, 32'hFFFFFFFF, 32'hA);
    add(C_ZHO | C_ZLO | C_MDRO, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hA);
    add(C_ZI, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hA);
    add(C_ZLO, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hA);

    foreach (tbl[i]) begin
      @(negedge clock);
      drive(tbl[i].c, tbl[i].md);
      #1;
      check($sformatf("vec%0d_bus", i), BusMuxOut, tbl[i].bus);
      check($sformatf("vec%0d_mar", i), MAR_q, tbl[i].mar);
      check($sformatf("vec%0d_ir", i), IR_q, tbl[i].ir);
    end

    // Reset mid-operation aborts the pending loads
    @(negedge clock);
    drive(C_MDRO | C_PCI | C_MARI | C_R1I, 32'h0);
    #1;
    check("abort_pre_bus", BusMuxOut, 32'hFFFFFFFF);
    clear = 1'b0;
    #1;
    check("abort_bus", BusMuxOut, 32'h0);
    check("abort_mar", MAR_q, 32'h0);
    check("abort_ir", IR_q, 32'h0);
    @(posedge clock);
    #1;
    check("abort_mar_edge", MAR_q, 32'h0);
    @(negedge clock);
    clear = 1'b1;
    drive(C_PCO, 32'h0);
    #1;
    check("abort_pc", BusMuxOut, 32'h0);
    drive(C_R1O, 32'h0);
    #1;
    check("abort_r1", BusMuxOut, 32'h0);

`ifdef DATAPATH_ROL_EN
    step("rol_ld_mdr", C_RD | C_MDRI, 32'h80000001, 32'h0);
    step("rol_ld_y", C_MDRO | C_YI, 32'h0, 32'h80000001);
    step("rol_ld_amt4", C_RD | C_MDRI, 32'h4, 32'h0);
    step("rol_op4", C_MDRO | C_ROL, 32'h0, 32'h4);
    step("rol_res4", C_ZLO, 32'h0, 32'h00000018);
    step("rol_ld_amt0", C_RD | C_MDRI, 32'h20, 32'h0);
    step("rol_op0", C_MDRO | C_ROL, 32'h0, 32'h20);
    step("rol_res0", C_ZLO, 32'h0, 32'h80000001);
    step("rol_res0_hi", C_ZHO, 32'h0, 32'h0);
    step("rol_vs_and", C_MDRO | C_ROL | C_AND, 32'h0, 32'h20);
    step("rol_vs_and_res", C_ZLO, 32'h0, 32'h0);
`endif

    // Randomized control words against the model
    @(negedge clock);
    drive(C_NONE, 32'h0);
    clear = 1'b0;
    #1 clear = 1'b1;
    model_reset();
    for (int n = 0; n < 300; n++) begin
      logic [19:0] c;
      logic [31:0] md;
      logic [31:0] eb;
      c = 20'd0;
      for (int b = 0; b < 20; b++)
        if ($urandom_range(0, 3) == 0) c[b] = 1'b1;
      md = $urandom;
      @(negedge clock);
      drive(c, md);
      #1;
      eb = model_bus(c);
      check("rnd_bus", BusMuxOut, eb);
      check("rnd_mar", MAR_q, m_mar);
      check("rnd_ir", IR_q, m_ir);
      model_step(c, md, eb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
